// File: rtl/sram_ctrl_pkg.sv
// Shared widths, opcode encodings and request record for the SRAM port controller.
package sram_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 11;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef struct packed {
        logic                      we;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_port_ctrl_if.sv
// Request and response streams between a datapath client and the SRAM port controller.
interface sram_port_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int DW = DEF_DATA_WIDTH,
    parameter int AW = DEF_ADDR_WIDTH
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_port_ctrl_chk.sv
// Simulation checks on the controller's internal response path.
module sram_port_ctrl_chk (
    input logic clk_i,
    input logic rst_i,
    input logic push_i,
    input logic full_i
);

    // The credit scheme must always leave room for every captured read.
    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_i));

endmodule

// File: rtl/sram_rsp_fifo.sv
// Read-response FIFO; the head entry is kept in its own register so the
// output does not pass through the storage read mux.
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DEF_DATA_WIDTH,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push_s, do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(DEPTH - 1)) begin
            r = '0;
        end else begin
            r = p + PW'(1'b1);
        end
        return r;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = head_q;

    // Next pointers, occupancy and head value for this cycle's push/pop.
    always_comb begin
        do_push_s = push_i & ~full_o;
        do_pop_s  = pop_i & ~empty_o;
        wr_ptr_d  = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = do_pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d   = count_q;
        head_d    = head_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
        if (count_q == '0) begin
            head_d = do_push_s ? push_data_i : head_q;
        end else if (do_pop_s) begin
            if (count_q == CW'(1'b1)) begin
                head_d = do_push_s ? push_data_i : head_q;
            end else begin
                head_d = mem_q[ptr_inc(rd_ptr_q)];
            end
        end else begin
            head_d = head_q;
        end
    end

    // Storage array; contents need no reset because occupancy gates every use.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Control state and head register with synchronous flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/sram_port_ctrl.sv
// Single-port SRAM initiator: registers request pins (S0), tracks reads
// through the macro (S1/S2), and returns read data through a credited FIFO.
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk0,
    input  logic                  rst,
    sram_port_ctrl_if.slave       bus,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic                  csb0_q, csb0_d;
    logic                  web0_q, web0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;
    logic                  rd_s1_q, rd_s1_d;
    logic                  rd_s2_q, rd_s2_d;
    logic [CW:0]           credit_used_s;
    logic                  req_ready_s, accept_s;
    logic [CW-1:0]         fifo_count_s;
    logic                  fifo_empty_s, fifo_full_s, fifo_pop_s;

    assign csb0  = csb0_q;
    assign web0  = web0_q;
    assign addr0 = addr0_q;
    assign din0  = din0_q;

    // Credit check: queued responses plus reads still inside the macro must fit the FIFO.
    always_comb begin
        credit_used_s = {1'b0, fifo_count_s} + (CW+1)'(rd_s1_q) + (CW+1)'(rd_s2_q);
        req_ready_s   = ~rst & (credit_used_s < (CW+1)'(RSP_DEPTH));
        accept_s      = bus.req_valid & req_ready_s;
    end

    assign bus.req_ready = req_ready_s;

    // S0 pin values and read-tracking flags for the next edge.
    always_comb begin
        csb0_d  = 1'b1;
        web0_d  = 1'b1;
        addr0_d = addr0_q;
        din0_d  = din0_q;
        if (accept_s) begin
            csb0_d  = 1'b0;
            web0_d  = (bus.req_we == OP_WR) ? 1'b0 : 1'b1;
            addr0_d = bus.req_addr;
            din0_d  = bus.req_wdata;
        end else begin
            csb0_d  = 1'b1;
            web0_d  = 1'b1;
        end
        rd_s1_d = accept_s & (bus.req_we == OP_RD);
        rd_s2_d = rd_s1_q;
    end

    // Pin registers and in-flight flags; reset drops any read already issued.
    always_ff @(posedge clk0) begin
        if (rst) begin
            csb0_q  <= 1'b1;
            web0_q  <= 1'b1;
            addr0_q <= '0;
            din0_q  <= '0;
            rd_s1_q <= 1'b0;
            rd_s2_q <= 1'b0;
        end else begin
            csb0_q  <= csb0_d;
            web0_q  <= web0_d;
            addr0_q <= addr0_d;
            din0_q  <= din0_d;
            rd_s1_q <= rd_s1_d;
            rd_s2_q <= rd_s2_d;
        end
    end

    assign fifo_pop_s    = ~fifo_empty_s & bus.rsp_ready;
    assign bus.rsp_valid = ~fifo_empty_s;

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk         (clk0),
        .rst         (rst),
        .push_i      (rd_s2_q),
        .push_data_i (dout0),
        .pop_i       (fifo_pop_s),
        .head_o      (bus.rsp_rdata),
        .count_o     (fifo_count_s),
        .empty_o     (fifo_empty_s),
        .full_o      (fifo_full_s)
    );

    sram_port_ctrl_chk u_chk (
        .clk_i  (clk0),
        .rst_i  (rst),
        .push_i (rd_s2_q),
        .full_i (fifo_full_s)
    );

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: SRAM macro model, transaction-level reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_sram_port_ctrl;
    import sram_ctrl_pkg::*;

    localparam int RSP_DEPTH = 4;

    logic        clk0;
    logic        rst;
    logic        csb0, web0;
    logic [10:0] addr0;
    logic [31:0] din0, dout0;

    sram_port_ctrl_if bus ();

    sram_port_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk0  (clk0),
        .rst   (rst),
        .bus   (bus),
        .csb0  (csb0),
        .web0  (web0),
        .addr0 (addr0),
        .din0  (din0),
        .dout0 (dout0)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    initial begin
        clk0 = 1'b0;
        forever #5 clk0 = ~clk0;
    end

    // SRAM macro model: pins captured at the edge, read data valid until the next edge.
    logic [31:0] sram_mem [2048];
    always @(posedge clk0) begin
        if (!csb0 && !web0) sram_mem[addr0] <= din0;
        if (!csb0 && web0) dout0 <= sram_mem[addr0];
        else               dout0 <= 32'h0BAD_F00D;
    end

    // Reference model: memory image updated at acceptance, reads due two edges later.
    typedef struct { logic [31:0] data; int due; } pend_t;
    pend_t       pend_q [$];
    logic [31:0] rdy_q  [$];
    logic [31:0] ref_mem [2048];
    logic        exp_csb = 1'b1, exp_web = 1'b1;
    logic [10:0] exp_addr = 11'd0;
    logic [31:0] exp_din = 32'd0;
    int          cyc = 0;
    bit          chk_en = 1'b0;
    logic [31:0] got_q [$];
    int          got_cyc [$];

    initial begin
        for (int i = 0; i < 2048; i++) begin
            sram_mem[i] = 32'hC0DE_0000 | 32'(i);
            ref_mem[i]  = 32'hC0DE_0000 | 32'(i);
        end
    end

    // Compare DUT against the model mid-cycle, then advance the model past the next edge.
    always @(negedge clk0) begin
        logic     exp_ready;
        logic     acc;
        exp_ready = !rst && ((rdy_q.size() + pend_q.size()) < RSP_DEPTH);
        if (chk_en) begin
            check("req_ready", {31'd0, bus.req_ready}, {31'd0, exp_ready});
            check("csb0", {31'd0, csb0}, {31'd0, exp_csb});
            check("web0", {31'd0, web0}, {31'd0, exp_web});
            check("addr0", {21'd0, addr0}, {21'd0, exp_addr});
            check("din0", din0, exp_din);
            check("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, rdy_q.size() > 0});
            if (rdy_q.size() > 0) check("rsp_rdata", bus.rsp_rdata, rdy_q[0]);
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            got_q.push_back(bus.rsp_rdata);
            got_cyc.push_back(cyc);
        end
        cyc++;
        if (rst) begin
            pend_q.delete();
            rdy_q.delete();
            exp_csb  = 1'b1;
            exp_web  = 1'b1;
            exp_addr = 11'd0;
            exp_din  = 32'd0;
        end else begin
            acc = bus.req_valid && exp_ready;
            if (rdy_q.size() > 0 && bus.rsp_ready) void'(rdy_q.pop_front());
            while (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                rdy_q.push_back(pend_q[0].data);
                void'(pend_q.pop_front());
            end
            if (acc) begin
                exp_csb  = 1'b0;
                exp_web  = !bus.req_we;
                exp_addr = bus.req_addr;
                exp_din  = bus.req_wdata;
                if (bus.req_we) ref_mem[bus.req_addr] = bus.req_wdata;
                else            pend_q.push_back('{ref_mem[bus.req_addr], cyc + 2});
            end else begin
                exp_csb = 1'b1;
                exp_web = 1'b1;
            end
        end
    end

    task automatic do_req(input logic we, input logic [10:0] a, input logic [31:0] d);
        int   budget = 0;
        logic hs = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (!hs && budget < 50) begin
            @(negedge clk0);
            hs = bus.req_ready;
            @(posedge clk0);
            budget++;
        end
        #1;
        bus.req_valid = 1'b0;
        if (!hs) begin
            total++;
            bad++;
            $display("FAIL req_timeout addr=%h", a);
        end
    endtask

    task automatic wait_rsp(input int n);
        int budget = 0;
        while (got_q.size() < n && budget < 60) begin
            @(posedge clk0);
            budget++;
        end
        #1;
        check("rsp_count", 32'(got_q.size()), 32'(n));
    endtask

    logic [10:0] rd_list  [6] = '{11'h000, 11'h001, 11'h002, 11'h005, 11'h000, 11'h001};
    logic [31:0] rd_exp   [6] = '{32'h11, 32'h22, 32'h33, 32'hDEADBEEF, 32'h11, 32'h22};

    initial begin
        int   base;
        int   idx;
        int   budget;
        logic hs;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 11'd0;
        bus.req_wdata = 32'd0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk0);
        #1;
        check("reset_csb0", {31'd0, csb0}, 32'd1);
        check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Idle after reset.
        repeat (10) @(posedge clk0);
        #1;
        check("idle_csb0", {31'd0, csb0}, 32'd1);
        check("idle_web0", {31'd0, web0}, 32'd1);
        check("idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Write then read the same address on the next cycle.
        do_req(1'b1, 11'h005, 32'hDEADBEEF);
        check("wr_csb0", {31'd0, csb0}, 32'd0);
        check("wr_web0", {31'd0, web0}, 32'd0);
        do_req(1'b0, 11'h005, 32'd0);
        check("rd_csb0", {31'd0, csb0}, 32'd0);
        check("rd_web0", {31'd0, web0}, 32'd1);
        @(posedge clk0); #1;
        check("raw_valid_k1", {31'd0, bus.rsp_valid}, 32'd0);
        @(posedge clk0); #1;
        check("raw_valid_k2", {31'd0, bus.rsp_valid}, 32'd1);
        check("raw_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        repeat (2) @(posedge clk0); #1;

        // Back-to-back reads at full rate.
        do_req(1'b1, 11'h000, 32'h11);
        do_req(1'b1, 11'h001, 32'h22);
        do_req(1'b1, 11'h002, 32'h33);
        base = got_q.size();
        idx  = cyc;
        for (int i = 0; i < 3; i++) do_req(1'b0, rd_list[i], 32'd0);
        check("b2b_edges", 32'(cyc - idx), 32'd3);
        wait_rsp(base + 3);
        for (int i = 0; i < 3; i++) check("b2b_data", got_q[base + i], rd_exp[i]);
        check("b2b_consec1", 32'(got_cyc[base + 1] - got_cyc[base]), 32'd1);
        check("b2b_consec2", 32'(got_cyc[base + 2] - got_cyc[base + 1]), 32'd1);

        // Backpressure: only RSP_DEPTH reads fit while the consumer stalls.
        bus.rsp_ready = 1'b0;
        bus.req_we    = 1'b0;
        base = got_q.size();
        idx  = 0;
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = (idx < 6);
            bus.req_addr  = rd_list[idx < 6 ? idx : 5];
            @(negedge clk0);
            hs = bus.req_valid && bus.req_ready;
            @(posedge clk0); #1;
            if (hs) idx++;
        end
        check("bp_accepted", 32'(idx), 32'd4);
        check("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("bp_no_rsp", 32'(got_q.size() - base), 32'd0);
        bus.rsp_ready = 1'b1;
        budget = 0;
        while (idx < 6 && budget < 40) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = rd_list[idx];
            @(negedge clk0);
            hs = bus.req_ready;
            @(posedge clk0); #1;
            if (hs) idx++;
            budget++;
        end
        bus.req_valid = 1'b0;
        check("bp_all_accepted", 32'(idx), 32'd6);
        wait_rsp(base + 6);
        for (int i = 0; i < 6; i++) check("bp_data", got_q[base + i], rd_exp[i]);
        check("bp_ready_back", {31'd0, bus.req_ready}, 32'd1);

        // Reset while a read is inside the macro; a write offered during reset is ignored.
        base = got_q.size();
        do_req(1'b0, 11'h7FF, 32'd0);
        rst           = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 11'h003;
        bus.req_wdata = 32'hBADBAD00;
        @(posedge clk0); #1;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        check("rst_csb0", {31'd0, csb0}, 32'd1);
        repeat (6) @(posedge clk0); #1;
        check("rst_no_rsp", 32'(got_q.size() - base), 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_csb0_late", {31'd0, csb0}, 32'd1);

        // Address extremes.
        do_req(1'b1, 11'h7FF, 32'hA5A5A5A5);
        do_req(1'b1, 11'h000, 32'h5A5A5A5A);
        do_req(1'b0, 11'h7FF, 32'd0);
        do_req(1'b0, 11'h000, 32'd0);
        do_req(1'b0, 11'h003, 32'd0);
        wait_rsp(base + 3);
        check("wrap_hi", got_q[base], 32'hA5A5A5A5);
        check("wrap_lo", got_q[base + 1], 32'h5A5A5A5A);
        check("rst_ignored_wr", got_q[base + 2], 32'hC0DE0003);

        repeat (4) @(posedge clk0);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
